// File: rtl/apb_pkg.sv
// Shared types and default constants for the single-slave APB initiator.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int APB_ADDR_W_DEF     = 8;
    localparam int APB_DATA_W_DEF     = 8;
    localparam int APB_TIMEOUT_DEF    = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// Clear/increment wait counter; o_expired flags the increment that reaches LIMIT.
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expires combinationally on the wait cycle that would bring the count to LIMIT.
    assign o_expired = i_inc && (r_cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-slave APB initiator: one command in, one SETUP/ACCESS transfer, one response out.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W_DEF,
    parameter int DATA_W         = APB_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_t r_state;
    apb_state_t w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_expired;
    logic              w_cmd_hs;
    logic              w_done;

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (r_state == SETUP),
        .i_inc    ((r_state == ACCESS) && !pready),
        .o_expired(w_expired)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_expired = 1'b0;
`endif

    assign w_cmd_hs = (r_state == IDLE) && cmd_valid;
    assign w_done   = (r_state == ACCESS) && (pready || w_expired);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = SETUP;
            end
            SETUP: begin
                psel   = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || w_expired) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request fields latch on the handshake and stay put until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_addr   <= cmd_addr;
                r_pwrite <= cmd_write;
                r_pwdata <= cmd_write ? cmd_wdata : '0;
            end
            // pready beats a same-cycle expiry, so a late ready still returns good data.
            if (w_done) begin
                r_rdata <= (pready && !r_pwrite) ? prdata : '0;
                r_err   <= !pready;
            end
        end
    end

    assign addr      = r_addr;
    assign pwdata    = r_pwdata;
    assign pwrite    = r_pwrite;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; the timeout scenario runs when APB_TIMEOUT_EN is defined.
module tb_apb_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic [7:0] addr, pwdata, prdata;
    logic       pwrite, psel, penable, pready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_master #(
        .ADDR_W(8),
        .DATA_W(8),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .addr(addr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready)
    );

    // Advance one clock; sampling and driving happen 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; prdata = 8'hEE; pready = 1;
        tick(); tick();
        checks++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {psel, penable, pwrite, rsp_valid, rsp_err});
        end
        checks++;
        if ({addr, pwdata, rsp_rdata} !== 24'h0) begin
            errors++; $display("FAIL reset_data: got %h want 000000", {addr, pwdata, rsp_rdata});
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        pready = 1; cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h05; cmd_wdata = 8'hA5;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_idle_ready: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 0; cmd_addr = 8'hFF; cmd_wdata = 8'h00;
        checks++;
        if ({psel, penable, pwrite, cmd_ready} !== 4'b1010 || addr !== 8'h05 || pwdata !== 8'hA5) begin
            errors++; $display("FAIL wr_setup: got sel/en/wr/rdy=%b addr=%h wdata=%h want 1010 05 a5",
                               {psel, penable, pwrite, cmd_ready}, addr, pwdata);
        end
        tick();
        checks++;
        if ({psel, penable, rsp_valid} !== 3'b110 || addr !== 8'h05 || pwdata !== 8'hA5) begin
            errors++; $display("FAIL wr_access: got sel/en/rv=%b addr=%h wdata=%h want 110 05 a5",
                               {psel, penable, rsp_valid}, addr, pwdata);
        end
        tick();
        checks++;
        if ({psel, penable, rsp_valid, rsp_err, cmd_ready} !== 5'b00100 || rsp_rdata !== 8'h00) begin
            errors++; $display("FAIL wr_resp: got sel/en/rv/err/rdy=%b rdata=%h want 00100 00",
                               {psel, penable, rsp_valid, rsp_err, cmd_ready}, rsp_rdata);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL wr_back_idle: got rv/rdy=%b want 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_read_wait();
        pready = 0; prdata = 8'hEE;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h0C; cmd_wdata = 8'h99;
        tick();
        cmd_valid = 0;
        checks++;
        if ({psel, penable, pwrite} !== 3'b100 || addr !== 8'h0C || pwdata !== 8'h00) begin
            errors++; $display("FAIL rd_setup: got sel/en/wr=%b addr=%h wdata=%h want 100 0c 00",
                               {psel, penable, pwrite}, addr, pwdata);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({psel, penable, rsp_valid} !== 3'b110 || addr !== 8'h0C) begin
                errors++; $display("FAIL rd_access_%0d: got sel/en/rv=%b addr=%h want 110 0c",
                                   i, {psel, penable, rsp_valid}, addr);
            end
            if (i == 3) begin pready = 1; prdata = 8'h3C; end
            tick();
        end
        pready = 0; prdata = 8'h55;
        checks++;
        if ({psel, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 8'h3C) begin
            errors++; $display("FAIL rd_resp: got sel/rv/err=%b rdata=%h want 010 3c",
                               {psel, rsp_valid, rsp_err}, rsp_rdata);
        end
    endtask

    // Entered with the read response pending; a second command waits behind it.
    task automatic test_backpressure();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h33;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({rsp_valid, cmd_ready, psel} !== 3'b100 || rsp_rdata !== 8'h3C) begin
                errors++; $display("FAIL bp_hold_%0d: got rv/rdy/sel=%b rdata=%h want 100 3c",
                                   i, {rsp_valid, cmd_ready, psel}, rsp_rdata);
            end
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        checks++;
        if ({rsp_valid, cmd_ready, psel} !== 3'b010 || rsp_rdata !== 8'h3C) begin
            errors++; $display("FAIL bp_release: got rv/rdy/sel=%b rdata=%h want 010 3c",
                               {rsp_valid, cmd_ready, psel}, rsp_rdata);
        end
        tick();
        cmd_valid = 0; pready = 1; prdata = 8'h77;
        checks++;
        if ({psel, penable} !== 2'b10 || addr !== 8'h33) begin
            errors++; $display("FAIL bp_next_setup: got sel/en=%b addr=%h want 10 33", {psel, penable}, addr);
        end
        tick(); tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h77) begin
            errors++; $display("FAIL bp_next_resp: got rv=%b rdata=%h want 1 77", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic test_reset_mid_access();
        pready = 0; cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h44; cmd_wdata = 8'h66;
        tick();
        cmd_valid = 0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001 || addr !== 8'h00) begin
            errors++; $display("FAIL rst_async: got sel/en/rv/rdy=%b addr=%h want 0001 00",
                               {psel, penable, rsp_valid, cmd_ready}, addr);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL rst_release: got rdy/sel/rv=%b want 100", {cmd_ready, psel, rsp_valid});
        end
        pready = 1; cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h5A; cmd_wdata = 8'h11;
        tick();
        cmd_valid = 0;
        checks++;
        if ({psel, penable, pwrite} !== 3'b101 || addr !== 8'h5A || pwdata !== 8'h11) begin
            errors++; $display("FAIL rst_next_setup: got sel/en/wr=%b addr=%h wdata=%h want 101 5a 11",
                               {psel, penable, pwrite}, addr, pwdata);
        end
        tick(); tick();
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 8'h00) begin
            errors++; $display("FAIL rst_next_resp: got rv/err=%b rdata=%h want 10 00", {rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        for (int run = 0; run < 2; run++) begin
            pready = 0; prdata = 8'h9C;
            cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h21;
            tick();
            cmd_valid = 0;
            tick();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({psel, penable} !== 2'b11) begin
                    errors++; $display("FAIL to_access_r%0d_%0d: got sel/en=%b want 11", run, i, {psel, penable});
                end
                if (run == 1 && i == 3) pready = 1;
                tick();
            end
            pready = 0;
            checks++;
            if (run == 0 && ({psel, rsp_valid, rsp_err} !== 3'b011 || rsp_rdata !== 8'h00)) begin
                errors++; $display("FAIL to_expire: got sel/rv/err=%b rdata=%h want 011 00",
                                   {psel, rsp_valid, rsp_err}, rsp_rdata);
            end
            if (run == 1 && ({psel, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 8'h9C)) begin
                errors++; $display("FAIL to_ready_wins: got sel/rv/err=%b rdata=%h want 010 9c",
                                   {psel, rsp_valid, rsp_err}, rsp_rdata);
            end
            rsp_ready = 1;
            tick();
            rsp_ready = 0;
        end
    endtask
`else
    task automatic test_no_timeout();
        pready = 0; prdata = 8'h9C;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h21;
        tick();
        cmd_valid = 0;
        tick();
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            errors++; $display("FAIL nto_still_waiting: got sel/en/rv=%b want 110", {psel, penable, rsp_valid});
        end
        pready = 1;
        tick();
        pready = 0;
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 8'h9C) begin
            errors++; $display("FAIL nto_resp: got rv/err=%b rdata=%h want 10 9c", {rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_backpressure();
        test_reset_mid_access();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
